// File: rtl/spu_ibuf_pkg.sv
// Shared types for the SPU instruction buffer: the stored entry layout and PC helpers.
package spu_ibuf_pkg;

  localparam int SPU_INSN_W = 32;

  typedef struct packed {
    logic [0:31] insn;
    logic [0:29] pc_word;
  } ibuf_entry_t;

  localparam int IBUF_ENTRY_W = $bits(ibuf_entry_t);

  function automatic logic [31:0] word_to_pc(input logic [29:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/spu_ibuf_ring.sv
// Circular entry storage: a multi-lane wrapping write port and a show-ahead
// multi-lane wrapping read port.
module spu_ibuf_ring
  import spu_ibuf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2,
  parameter int AW      = $clog2(DEPTH),
  parameter int FCW     = $clog2(FETCH_W) + 1
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_ptr,
  input  logic [FCW-1:0]                  wr_cnt,
  input  logic [IBUF_ENTRY_W*FETCH_W-1:0] wr_data,
  input  logic [AW-1:0]                   rd_ptr,
  output logic [IBUF_ENTRY_W*ISSUE_W-1:0] rd_data
);

  ibuf_entry_t mem_q [DEPTH];

  // DEPTH is a power of two, so truncating the pointer sum gives the wrap.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (k < int'(wr_cnt)) begin
          mem_q[AW'(int'(wr_ptr) + k)] <= wr_data[k*IBUF_ENTRY_W +: IBUF_ENTRY_W];
        end
      end
    end
  end

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_rd
    assign rd_data[gi*IBUF_ENTRY_W +: IBUF_ENTRY_W] = mem_q[rd_ptr + AW'(gi)];
  end

endmodule

// File: rtl/spu_ibuf.sv
// Fetch-to-decode instruction buffer: pointers, occupancy, issue-group sizing
// and flush handling around the spu_ibuf_ring storage.
module spu_ibuf
  import spu_ibuf_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FETCH_W     = 4,
  parameter int ISSUE_W     = 2,
  parameter int ALIGN_GROUP = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [0:31]                   fill_pc,
  input  logic [$clog2(FETCH_W):0]      fill_cnt,
  input  logic [32*FETCH_W-1:0]         fill_insn,
  input  logic                          flush,
  input  logic                          stall,
  output logic [ISSUE_W-1:0]            out_valid,
  output logic [32*ISSUE_W-1:0]         out_insn,
  output logic [32*ISSUE_W-1:0]         out_pc,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FCW = $clog2(FETCH_W) + 1;
  localparam int GW  = $clog2(ISSUE_W) + 1;
  localparam int EW  = IBUF_ENTRY_W;

  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           fill_acc;
  logic [FCW-1:0] fill_n;
  logic [GW-1:0]  grp_n;
  logic [GW-1:0]  pop_n;
  logic [29:0]    fill_word;
  logic           unused_pc_bits;

  logic [EW*FETCH_W-1:0] wr_data;
  logic [EW*ISSUE_W-1:0] rd_data;
  ibuf_entry_t           rd_ent [ISSUE_W];

  assign fill_word      = fill_pc[0:29];
  assign unused_pc_bits = ^fill_pc[30:31];
  assign count          = count_q;

  // Deliberately ignores any pop in the same cycle.
  assign fill_ready = (int'(count_q) <= DEPTH - FETCH_W);
  assign fill_acc   = fill_valid && fill_ready && !flush;

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_wr
    assign wr_data[gi*EW +: EW] = {fill_insn[gi*SPU_INSN_W +: SPU_INSN_W], fill_word + 30'(gi)};
  end

  spu_ibuf_ring #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .AW      (AW),
    .FCW     (FCW)
  ) u_ring (
    .clk     (clk),
    .wr_en   (fill_acc && !rst),
    .wr_ptr  (tail_q),
    .wr_cnt  (fill_cnt),
    .wr_data (wr_data),
    .rd_ptr  (head_q),
    .rd_data (rd_data)
  );

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_rd
    assign rd_ent[gi] = rd_data[gi*EW +: EW];
  end

  // Largest PC-contiguous prefix that fits the occupancy and, when enabled,
  // stays inside the ISSUE_W-word aligned block of the head instruction.
  always_comb begin
    logic run_ok;
    int   align_lim;
    grp_n     = '0;
    run_ok    = 1'b1;
    align_lim = ISSUE_W - int'(rd_ent[0].pc_word & 30'(ISSUE_W - 1));
    for (int n = 1; n <= ISSUE_W; n++) begin
      if (rd_ent[n-1].pc_word != rd_ent[0].pc_word + 30'(n - 1)) begin
        run_ok = 1'b0;
      end
      if (run_ok && (n <= int'(count_q)) && ((ALIGN_GROUP == 0) || (n <= align_lim))) begin
        grp_n = GW'(n);
      end
    end
  end

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_out
    logic lane_v;
    assign lane_v                      = (GW'(gi) < grp_n);
    assign out_valid[gi]               = lane_v;
    assign out_insn[gi*32 +: 32]       = lane_v ? rd_ent[gi].insn : '0;
    assign out_pc[gi*32 +: 32]         = lane_v ? word_to_pc(rd_ent[gi].pc_word) : '0;
  end

  always_comb begin
    fill_n  = fill_acc ? fill_cnt : '0;
    pop_n   = (!stall && !flush) ? grp_n : '0;
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(fill_n);
    count_d = count_q + CW'(fill_n) - CW'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  a_fill_cnt_range : assert property (@(posedge clk) disable iff (rst)
    int'(fill_cnt) <= FETCH_W);
  a_no_write_full : assert property (@(posedge clk) disable iff (rst)
    fill_acc |-> fill_ready);
  a_valid_contig : assert property (@(posedge clk) disable iff (rst)
    (out_valid & (out_valid + ISSUE_W'(1))) == '0);

endmodule

// File: tb/tb_spu_ibuf.sv
// Self-checking bench for spu_ibuf: directed scenarios then random traffic,
// all compared against a queue-based model of the buffer.
module tb_spu_ibuf;

  localparam int DEPTH       = 16;
  localparam int FETCH_W     = 4;
  localparam int ISSUE_W     = 2;
  localparam int ALIGN_GROUP = 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       fill_valid;
  logic                       fill_ready;
  logic [31:0]                fill_pc;
  logic [$clog2(FETCH_W):0]   fill_cnt;
  logic [32*FETCH_W-1:0]      fill_insn;
  logic                       flush;
  logic                       stall;
  logic [ISSUE_W-1:0]         out_valid;
  logic [32*ISSUE_W-1:0]      out_insn;
  logic [32*ISSUE_W-1:0]      out_pc;
  logic [$clog2(DEPTH+1)-1:0] count;

  spu_ibuf #(
    .DEPTH       (DEPTH),
    .FETCH_W     (FETCH_W),
    .ISSUE_W     (ISSUE_W),
    .ALIGN_GROUP (ALIGN_GROUP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_pc    (fill_pc),
    .fill_cnt   (fill_cnt),
    .fill_insn  (fill_insn),
    .flush      (flush),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_insn   (out_insn),
    .out_pc     (out_pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [29:0] w;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Group size from the buffer rules: contiguous PCs, bounded by occupancy,
  // issue width and (optionally) the aligned ISSUE_W-word block.
  function automatic int model_g();
    int n   = 0;
    int lim = ISSUE_W;
    if (mq.size() == 0) return 0;
    if (ALIGN_GROUP != 0) lim = ISSUE_W - int'(mq[0].w % ISSUE_W);
    for (int i = 0; i < ISSUE_W && i < mq.size() && i < lim; i++) begin
      if (mq[i].w != 30'(mq[0].w + i)) break;
      n = i + 1;
    end
    return n;
  endfunction

  task automatic compare_outputs();
    int          g;
    logic [63:0] e_valid, e_insn, e_pc;
    g       = model_g();
    e_valid = '0;
    e_insn  = '0;
    e_pc    = '0;
    for (int i = 0; i < g; i++) begin
      e_valid[i]        = 1'b1;
      e_insn[i*32 +: 32] = mq[i].insn;
      e_pc[i*32 +: 32]   = {mq[i].w, 2'b00};
    end
    chk("count", 64'(count), 64'(mq.size()));
    chk("fill_ready", 64'(fill_ready), 64'(mq.size() <= DEPTH - FETCH_W));
    chk("out_valid", 64'(out_valid), e_valid);
    chk("out_insn", 64'(out_insn), e_insn);
    chk("out_pc", 64'(out_pc), e_pc);
  endtask

  task automatic cycle(input logic r, input logic fv, input logic [31:0] pc, input int cnt,
                       input logic fl, input logic st);
    int g;
    bit rdy;
    @(negedge clk);
    cyc++;
    if (chk_en) compare_outputs();
    rst        = r;
    fill_valid = fv;
    fill_pc    = pc;
    fill_cnt   = ($clog2(FETCH_W)+1)'(cnt);
    for (int k = 0; k < FETCH_W; k++) fill_insn[k*32 +: 32] = $urandom();
    flush      = fl;
    stall      = st;
    if (r || fl) begin
      mq.delete();
      $display("cyc %0d: %s", cyc, r ? "reset" : "flush");
    end else begin
      g   = model_g();
      rdy = (mq.size() <= DEPTH - FETCH_W);
      if (!st && g > 0) begin
        $display("cyc %0d: issue %0d insn from pc %08h", cyc, g, {mq[0].w, 2'b00});
        repeat (g) void'(mq.pop_front());
      end
      if (fv && rdy) begin
        for (int k = 0; k < cnt; k++) begin
          ent_t e;
          e.insn = fill_insn[k*32 +: 32];
          e.w    = 30'((pc >> 2) + k);
          mq.push_back(e);
        end
        if (cnt > 0) $display("cyc %0d: fill %0d insn at pc %08h", cyc, cnt, pc);
      end
    end
  endtask

  task automatic idle(input int n, input logic st);
    repeat (n) cycle(1'b0, 1'b0, 32'h0, 0, 1'b0, st);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    int          rcnt;
    rst = 1'b1; fill_valid = 1'b0; fill_pc = '0; fill_cnt = '0;
    fill_insn = '0; flush = 1'b0; stall = 1'b0;

    // 1: reset state
    cycle(1'b1, 1'b1, 32'h80, 4, 1'b0, 1'b0);
    chk_en = 1;
    cycle(1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    idle(1, 1'b0);
    post_edge();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(fill_ready), 64'd1);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_insn", 64'(out_insn), 64'd0);

    // 2: simple pairwise drain
    cycle(1'b0, 1'b1, 32'h100, 4, 1'b0, 1'b0);
    post_edge();
    chk("t2_valid", 64'(out_valid), 64'h3);
    chk("t2_pc", 64'(out_pc), 64'h0000_0104_0000_0100);
    idle(3, 1'b0);

    // 3: misaligned head issues alone
    cycle(1'b0, 1'b1, 32'h104, 3, 1'b0, 1'b0);
    post_edge();
    chk("t3_valid", 64'(out_valid), 64'h1);
    idle(3, 1'b0);

    // 4: fill to full under stall, then drain across the wrap
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h500 + 32'(i*16), 4, 1'b0, 1'b1);
    post_edge();
    chk("t4_full", 64'(count), 64'd16);
    chk("t4_ready", 64'(fill_ready), 64'd0);
    idle(8, 1'b0);
    post_edge();
    chk("t4_empty", 64'(count), 64'd0);

    // 5: flush beats same-cycle fill
    cycle(1'b0, 1'b1, 32'h600, 4, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h610, 4, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h620, 2, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h700, 4, 1'b1, 1'b0);
    post_edge();
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 1'b1, 32'h400, 4, 1'b0, 1'b0);
    post_edge();
    chk("t5_pc0", 64'(out_pc[31:0]), 64'h400);
    idle(3, 1'b0);

    // 6: no pairing across a PC discontinuity
    cycle(1'b0, 1'b1, 32'h200, 1, 1'b0, 1'b0);
    post_edge();
    chk("t6_valid", 64'(out_valid), 64'h1);
    cycle(1'b0, 1'b1, 32'h300, 4, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Random traffic
    rpc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      logic r, fv, fl, st;
      r    = ($urandom_range(0, 99) == 0);
      fl   = ($urandom_range(0, 29) == 0);
      st   = ($urandom_range(0, 9) < 3);
      fv   = ($urandom_range(0, 9) < 6);
      rcnt = $urandom_range(0, FETCH_W);
      if ($urandom_range(0, 9) < 3) rpc = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      cycle(r, fv, rpc, rcnt, fl, st);
      if (fv && !r && !fl) rpc = rpc + 32'(4 * rcnt);
    end
    idle(12, 1'b0);
    @(negedge clk);
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spu_ibuf.md
Name: spu_ibuf

Overview:
Parametrised instruction buffer between the fetch stage and the decode/dependency stages of the SPU core. It generalises the fixed two-instruction (even/odd) fetch-to-decode handoff to a configurable fetch width, issue width and buffer depth. Instructions are stored with their PCs in a circular buffer. Each cycle the buffer presents up to ISSUE_W in-order instructions as an issue group. It supports stall back-pressure, a branch flush, and optional aligned-group issue for the even/odd pipes.

Parameters:
DEPTH, 16, entry count; power of 2; must be >= FETCH_W+ISSUE_W
FETCH_W, 4, maximum instructions written per fill
ISSUE_W, 2, maximum instructions issued per cycle; power of 2
ALIGN_GROUP, 1, 1 = an issue group may not cross an ISSUE_W-word aligned PC boundary

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fill_valid  in  1  fill request
fill_ready  out  1  buffer can accept a full fill
fill_pc  in  32  byte PC of fill lane 0; bits [30:31] ignored
fill_cnt  in  $clog2(FETCH_W)+1  valid lanes, 0..FETCH_W, packed from lane 0
fill_insn  in  32*FETCH_W  instructions; lane k at PC fill_pc+4k
flush  in  1  branch taken; discard buffer contents
stall  in  1  decode or dependency stall; blocks issue
out_valid  out  ISSUE_W  per-lane valid, contiguous from lane 0
out_insn  out  32*ISSUE_W  issue-group instructions
out_pc  out  32*ISSUE_W  issue-group byte PCs
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (sync, rst=1 at clock edge):
  - head = tail = 0, count = 0
  - out_valid = 0, out_insn = 0, out_pc = 0, fill_ready = 1
  - Reset asserted mid-operation discards all entries; a fill or flush in the same cycle is ignored.
- Storage: each entry holds {insn[32], pc_word[30]}. head and tail wrap modulo DEPTH.
- fill_ready = (DEPTH - count) >= FETCH_W, computed from the registered count only. It does not credit a pop in the same cycle; this is deliberately conservative.
- Fill: when fill_valid && fill_ready && !flush, write fill_cnt entries at tail..tail+fill_cnt-1 (wrapping), then tail += fill_cnt.
  - fill_cnt = 0 is a legal no-op.
  - fill_valid with fill_ready=0 is ignored; fetch holds the request.
- Issue view is show-ahead and combinational from registered state. An entry written at edge N is visible in the cycle after edge N.
- Group size g is the largest n <= min(count, ISSUE_W) satisfying both:
  - contiguity: entry i has pc_word equal to entry 0's pc_word + i, for every i < n;
  - alignment (ALIGN_GROUP=1 only): n <= ISSUE_W - (head pc_word mod ISSUE_W).
- Group outputs: out_valid lanes 0..g-1 = 1, all other lanes 0. Invalid lanes drive insn = 0 and pc = 0.
- Pop: if !stall && !flush, head += g and count decreases by g.
  - With stall=1, outputs hold stable.
  - With count=0, g=0 and nothing pops.
- Count update: count_next = count + accepted fill_cnt - popped g. Fill and pop in the same cycle are both applied.
- Flush has priority over fill and pop. On flush: head = tail = 0, count = 0, and the same-cycle fill is dropped. out_valid = 0 in the cycle after flush. The fetch stage refills from the new PC on a later cycle.
- Full: count never exceeds DEPTH; this is guaranteed by the fill_ready rule.
- Assertions (simulation only):
  - fill_cnt <= FETCH_W
  - no write while !fill_ready
  - out_valid is contiguous from lane 0

Decomposition:
- Add to defines_pkg:
  - SPU_INSN_W = 32
  - typedef struct packed {logic [0:31] insn; logic [0:29] pc_word;} ibuf_entry_t
- Sub-module spu_ibuf_ring: DEPTH x ibuf_entry_t storage, with a FETCH_W-lane wrapping write port and an ISSUE_W-lane wrapping read port.
- spu_ibuf holds the pointers, count, group-size logic and flush handling.

Test Plan:
1. Reset release, no fills -> count=0, out_valid=2'b00, fill_ready=1; all outputs zero.
2. Fill pc=0x100, cnt=4, stall=0 -> next cycle out_valid=2'b11 with pcs 0x100/0x104; following cycle 0x108/0x10C; then out_valid=2'b00, count=0.
3. ALIGN_GROUP=1, fill pc=0x104, cnt=3 -> first group out_valid=2'b01 (0x104 alone); next group 0x108/0x10C as 2'b11.
4. stall=1, four fills of cnt=4 -> count=16, fill_ready=0, fifth fill ignored. Release stall -> 8 groups issue in PC order across the pointer wrap; count=0 after 8 cycles.
5. count=10, then flush=1 with fill_valid=1 in the same cycle -> next cycle count=0, out_valid=0, fill dropped. A refill at pc=0x400 then issues 0x400 first.
6. Fill pc=0x200 cnt=1, then fill pc=0x300 cnt=4, stall=0 -> groups {0x200} (out_valid=2'b01), then 0x300/0x304, then 0x308/0x30C (no pairing across the PC discontinuity).
